can_frame_transmitter: RTL

//  Transmit side of the CAN decoder: serialises one CAN 2.0A standard data/remote frame onto TX, one bit per SP edge.

---
 rtl/can_frame_transmitter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/can_frame_transmitter.sv
// Transmit side of a CAN 2.0A controller: serialises one standard data/remote frame onto TX,
// one bit per SP edge, with bit stuffing, CRC-15 and RX monitoring (arbitration, bit, ACK errors).
module can_frame_transmitter #(
  parameter int MAX_BYTES = 8,
  parameter int IFS_BITS  = 3
) (
  input  logic        SP,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] ID,
  input  logic        RTR,
  input  logic [3:0]  DLC,
  input  logic [63:0] DATA,
  input  logic        RX,
  output logic        TX,
  output logic        BUSY,
  output logic        DONE,
  output logic        ARB_LOST,
  output logic        BIT_Error,
  output logic        ACK_Error
);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL,
    S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS, S_FIN
  } state_t;

  typedef enum logic [1:0] {C_NONE, C_BIT, C_ARB, C_ACK} chk_t;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[14];
    crc15_step = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

  state_t      state_r, state_nxt, field_next_s;
  logic [6:0]  cnt_r, cnt_nxt, field_len_s;
  logic [10:0] id_r;
  logic        rtr_r;
  logic [3:0]  dlc_r;
  logic [63:0] data_r;
  logic [6:0]  nbits_r;
  logic [14:0] crc_r, crc_nxt;
  logic [2:0]  run_r, run_nxt;
  logic        tx_r, tx_nxt;
  chk_t        chk_r, chk_nxt, field_cls_s;
  logic        stf_r, stf_nxt;
  logic        busy_r, busy_nxt, done_r, done_nxt, arb_r, arb_nxt;
  logic        biterr_r, biterr_nxt, ackerr_r, ackerr_nxt;
  logic        field_bit_s, field_stf_s, field_crc_s, last_s, stuff_s;
  logic        arb_lost_s, bit_err_s, ack_err_s, abort_s, accept_s;
  logic [11:0] arb_bits_s;
  logic [5:0]  ctrl_bits_s;
  logic [3:0]  n_bytes_s;

  assign accept_s    = (state_r == S_IDLE) && start;
  assign n_bytes_s   = RTR ? 4'd0 : ((DLC > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : DLC);
  assign arb_bits_s  = {id_r, rtr_r};
  assign ctrl_bits_s = {2'b00, dlc_r};

  // chk_r/tx_r describe the bit that has just ended on this edge
  assign arb_lost_s = (chk_r == C_ARB) && tx_r && !RX;
  assign bit_err_s  = (chk_r == C_BIT) && (RX != tx_r);
  assign ack_err_s  = (chk_r == C_ACK) && RX;
  assign abort_s    = arb_lost_s || bit_err_s || ack_err_s;
  assign stuff_s    = stf_r && (run_r == 3'd5);
  assign last_s     = (cnt_r == (field_len_s - 7'd1));

  // Value, length, monitor class and successor of the field whose bit goes out next
  always_comb begin
    field_bit_s  = 1'b1;
    field_len_s  = 7'd1;
    field_cls_s  = C_BIT;
    field_stf_s  = 1'b0;
    field_crc_s  = 1'b0;
    field_next_s = S_IDLE;
    case (state_r)
      S_SOF: begin
        field_bit_s = 1'b0; field_stf_s = 1'b1; field_crc_s = 1'b1; field_next_s = S_ARB;
      end
      S_ARB: begin
        field_bit_s = arb_bits_s[4'd11 - cnt_r[3:0]]; field_len_s = 7'd12; field_cls_s = C_ARB;
        field_stf_s = 1'b1; field_crc_s = 1'b1; field_next_s = S_CTRL;
      end
      S_CTRL: begin
        field_bit_s = ctrl_bits_s[3'd5 - cnt_r[2:0]]; field_len_s = 7'd6;
        field_stf_s = 1'b1; field_crc_s = 1'b1;
        field_next_s = (nbits_r == 7'd0) ? S_CRC : S_DATA;
      end
      S_DATA: begin
        field_bit_s = data_r[6'd63 - cnt_r[5:0]]; field_len_s = nbits_r;
        field_stf_s = 1'b1; field_crc_s = 1'b1; field_next_s = S_CRC;
      end
      S_CRC: begin
        field_bit_s = crc_r[4'd14 - cnt_r[3:0]]; field_len_s = 7'd15;
        field_stf_s = 1'b1; field_next_s = S_CRC_DEL;
      end
      S_CRC_DEL:  field_next_s = S_ACK_SLOT;
      S_ACK_SLOT: begin field_cls_s = C_ACK; field_next_s = S_ACK_DEL; end
      S_ACK_DEL:  field_next_s = S_EOF;
      S_EOF:      begin field_len_s = 7'd7; field_next_s = S_IFS; end
      S_IFS:      begin field_len_s = 7'(IFS_BITS); field_cls_s = C_NONE; field_next_s = S_FIN; end
      default: begin
        field_cls_s  = C_NONE;
        field_next_s = S_IDLE;
      end
    endcase
  end

  // Next state and in-field counter; a stuff bit holds both
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    if (state_r == S_IDLE) begin
      cnt_nxt   = 7'd0;
      state_nxt = start ? S_SOF : S_IDLE;
    end else if (abort_s || (state_r == S_FIN)) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 7'd0;
    end else if (stuff_s) begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
    end else if (last_s) begin
      state_nxt = field_next_s;
      cnt_nxt   = 7'd0;
    end else begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r + 7'd1;
    end
  end

  // Next bus bit, CRC, stuff run length, status and pulses
  always_comb begin
    tx_nxt     = tx_r;
    chk_nxt    = chk_r;
    stf_nxt    = stf_r;
    run_nxt    = run_r;
    crc_nxt    = crc_r;
    busy_nxt   = busy_r;
    done_nxt   = 1'b0;
    arb_nxt    = 1'b0;
    biterr_nxt = 1'b0;
    ackerr_nxt = 1'b0;
    if (state_r == S_IDLE) begin
      tx_nxt = 1'b1; chk_nxt = C_NONE; stf_nxt = 1'b0;
      run_nxt = 3'd0; crc_nxt = 15'h0000; busy_nxt = start;
    end else if (abort_s) begin
      tx_nxt = 1'b1; chk_nxt = C_NONE; stf_nxt = 1'b0; busy_nxt = 1'b0;
      arb_nxt = arb_lost_s; biterr_nxt = bit_err_s; ackerr_nxt = ack_err_s;
    end else if (state_r == S_FIN) begin
      tx_nxt = 1'b1; chk_nxt = C_NONE; stf_nxt = 1'b0; busy_nxt = 1'b0; done_nxt = 1'b1;
    end else if (stuff_s) begin
      tx_nxt  = ~tx_r;
      run_nxt = 3'd1;
    end else begin
      tx_nxt  = field_bit_s;
      chk_nxt = field_cls_s;
      stf_nxt = field_stf_s;
      run_nxt = (field_bit_s == tx_r) ? (run_r + 3'd1) : 3'd1;
      if (field_crc_s) begin
        crc_nxt = crc15_step(crc_r, field_bit_s);
      end else begin
        crc_nxt = crc_r;
      end
    end
  end

  // State register
  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 7'd0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Frame latches, datapath and registered outputs
  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      id_r <= 11'h000; rtr_r <= 1'b0; dlc_r <= 4'h0; data_r <= 64'h0; nbits_r <= 7'd0;
      crc_r <= 15'h0000; run_r <= 3'd0; tx_r <= 1'b1; chk_r <= C_NONE; stf_r <= 1'b0;
      busy_r <= 1'b0; done_r <= 1'b0; arb_r <= 1'b0; biterr_r <= 1'b0; ackerr_r <= 1'b0;
    end else begin
      if (accept_s) begin
        id_r    <= ID;
        rtr_r   <= RTR;
        dlc_r   <= DLC;
        data_r  <= DATA;
        nbits_r <= {n_bytes_s, 3'b000};
      end
      crc_r    <= crc_nxt;
      run_r    <= run_nxt;
      tx_r     <= tx_nxt;
      chk_r    <= chk_nxt;
      stf_r    <= stf_nxt;
      busy_r   <= busy_nxt;
      done_r   <= done_nxt;
      arb_r    <= arb_nxt;
      biterr_r <= biterr_nxt;
      ackerr_r <= ackerr_nxt;
    end
  end

  assign TX        = tx_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign ARB_LOST  = arb_r;
  assign BIT_Error = biterr_r;
  assign ACK_Error = ackerr_r;

endmodule
